// File: rtl/commu_sched_if.sv
// ---------------------------------------------------------------------------
// commu_sched_if
//   Link bundle between the baud-sweep scheduler and the RX/TX tops.
//
//   tbit_period  20  bit period shared by RX and TX
//   tx_pattern    1  pattern mode enable for RX and TX
//   tx_req        1  byte send request
//   tx_data       8  byte offered with tx_req
//   tx_ack        1  TX accepted the offered byte this cycle
//   rx_total     32  cumulative good-byte count reported by RX
//
//   master: the scheduler side (drives period, pattern and the TX request)
//   slave : the RX/TX side (drives the ack and the RX byte counter)
// ---------------------------------------------------------------------------
interface commu_sched_if;
  logic [19:0] tbit_period;
  logic        tx_pattern;
  logic        tx_req;
  logic [7:0]  tx_data;
  logic        tx_ack;
  logic [31:0] rx_total;

  modport master (
    output tbit_period,
    output tx_pattern,
    output tx_req,
    output tx_data,
    input  tx_ack,
    input  rx_total
  );

  modport slave (
    input  tbit_period,
    input  tx_pattern,
    input  tx_req,
    input  tx_data,
    output tx_ack,
    output rx_total
  );
endinterface

// File: rtl/commu_sched.sv
// ---------------------------------------------------------------------------
// commu_sched
//   Baud-sweep link test scheduler. For every entry of the period table it
//   programs tbit_period, lets the link settle, sends a burst of pattern
//   bytes through TX and then watches the RX good-byte counter to decide
//   whether that bit period passed. Results are collected in pass_map.
//
// Ports
//   clk_sys     system clock
//   rst         synchronous reset, active-high
//   start       one-cycle request to run a sweep (ignored while running)
//   abort       one-cycle request to stop a running sweep
//   period_tab  packed period table, step k at [20k+19:20k]
//   link        scheduler side of the RX/TX link bundle
//   busy        sweep in progress
//   done        one-cycle pulse when a sweep completes normally
//   step_idx    current step
//   pass_map    bit k set when step k passed
//
// Every output is a register; the "_next" values are derived from the
// next FSM state so outputs line up with the state they belong to.
// ---------------------------------------------------------------------------
module commu_sched #(
  parameter int N_STEP         = 4,
  parameter int BYTES_PER_STEP = 16,
  parameter int SETTLE_CYC     = 64,
  parameter int TIMEOUT_CYC    = 2000000
) (
  input  logic                  clk_sys,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [20*N_STEP-1:0]  period_tab,
  commu_sched_if.master         link,
  output logic                  busy,
  output logic                  done,
  output logic [3:0]            step_idx,
  output logic [N_STEP-1:0]     pass_map
);

  // Settle counter runs 0..SETTLE_CYC-1.
  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_SNAP, S_SEND, S_WAIT, S_JUDGE, S_DONE
  } state_t;

  state_t state_reg, state_next;

  logic [3:0]        step_reg, step_next;
  logic [SW-1:0]     settle_reg, settle_next;
  logic [7:0]        byte_cnt_reg, byte_cnt_next;
  logic [23:0]       tmo_reg, tmo_next;
  logic [31:0]       base_reg, base_next;
  logic              pass_reg, pass_next;
  logic [19:0]       tbit_reg, tbit_next;
  logic              pattern_reg, pattern_next;
  logic              req_reg, req_next;
  logic [7:0]        data_reg, data_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic [N_STEP-1:0] map_reg, map_next;

  // Unpacked view of the period table.
  logic [19:0] tab_arr [N_STEP];
  logic [19:0] tab_sel;

  for (genvar gi = 0; gi < N_STEP; gi++) begin : g_tab
    assign tab_arr[gi] = period_tab[20*gi +: 20];
  end

  // Handshake and judgement terms.
  logic        hit;
  logic        last_byte;
  logic [31:0] delta;
  logic        rx_ok;
  logic        tmo_hit;

  assign hit       = req_reg & link.tx_ack;
  assign last_byte = (byte_cnt_reg == 8'(BYTES_PER_STEP - 1));
  // Modulo subtraction keeps the check correct across an rx_total wrap.
  assign delta     = link.rx_total - base_reg;
  assign rx_ok     = (delta >= 32'(BYTES_PER_STEP));
  assign tmo_hit   = (tmo_reg == 24'(TIMEOUT_CYC - 1));

  // -------------------------------------------------------------------------
  // State register (plus the datapath and output registers)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      step_reg     <= 4'd0;
      settle_reg   <= '0;
      byte_cnt_reg <= 8'd0;
      tmo_reg      <= 24'd0;
      base_reg     <= 32'd0;
      pass_reg     <= 1'b0;
      tbit_reg     <= period_tab[19:0];
      pattern_reg  <= 1'b0;
      req_reg      <= 1'b0;
      data_reg     <= 8'd0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      map_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      step_reg     <= step_next;
      settle_reg   <= settle_next;
      byte_cnt_reg <= byte_cnt_next;
      tmo_reg      <= tmo_next;
      base_reg     <= base_next;
      pass_reg     <= pass_next;
      tbit_reg     <= tbit_next;
      pattern_reg  <= pattern_next;
      req_reg      <= req_next;
      data_reg     <= data_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      map_reg      <= map_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start) state_next = S_SETUP;
      S_SETUP: if (settle_reg == SW'(SETTLE_CYC - 1)) state_next = S_SNAP;
      S_SNAP:  state_next = S_SEND;
      S_SEND:  if (hit && last_byte) state_next = S_WAIT;
      // rx_ok is tested first in effect: either one ends the wait, and the
      // pass flag below is taken from rx_ok, so a tie records a pass.
      S_WAIT:  if (rx_ok || tmo_hit) state_next = S_JUDGE;
      S_JUDGE: state_next = (step_reg == 4'(N_STEP - 1)) ? S_DONE : S_SETUP;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    // Abort overrides every other transition.
    if (abort && (state_reg != S_IDLE)) state_next = S_IDLE;
  end

  // Period for the step being entered.
  always_comb begin
    tab_sel = tab_arr[0];
    for (int k = 0; k < N_STEP; k++) begin
      if (step_next == 4'(k)) tab_sel = tab_arr[k];
    end
  end

  // -------------------------------------------------------------------------
  // Output / datapath logic
  // -------------------------------------------------------------------------
  always_comb begin
    step_next     = step_reg;
    settle_next   = settle_reg;
    byte_cnt_next = byte_cnt_reg;
    tmo_next      = 24'd0;
    base_next     = base_reg;
    pass_next     = pass_reg;
    tbit_next     = tbit_reg;
    map_next      = map_reg;
    data_next     = data_reg;

    // Step index: restart on a new sweep, advance between steps.
    if (state_reg == S_IDLE && state_next == S_SETUP) begin
      step_next = 4'd0;
      map_next  = '0;
    end else if (state_reg == S_JUDGE && state_next == S_SETUP) begin
      step_next = step_reg + 4'd1;
    end

    // The period only changes when SETUP is entered.
    if (state_next == S_SETUP) begin
      if (state_reg == S_SETUP) begin
        settle_next = settle_reg + 1'b1;
      end else begin
        settle_next = '0;
        tbit_next   = tab_sel;
      end
    end

    if (state_reg == S_SNAP) begin
      base_next     = link.rx_total;
      byte_cnt_next = 8'd0;
    end else if (state_reg == S_SEND && hit) begin
      byte_cnt_next = byte_cnt_reg + 8'd1;
    end

    // The timeout counter is zero everywhere except while waiting.
    if (state_reg == S_WAIT) begin
      tmo_next  = tmo_reg + 24'd1;
      pass_next = rx_ok;
    end

    // An abort out of JUDGE leaves that step unrecorded.
    if (state_reg == S_JUDGE && state_next != S_IDLE) begin
      for (int k = 0; k < N_STEP; k++) begin
        if (step_reg == 4'(k)) map_next[k] = pass_reg;
      end
    end

    if (state_next == S_SEND) data_next = {step_reg, byte_cnt_next[3:0]};

    // The request drops for one cycle after every accepted byte.
    req_next     = (state_next == S_SEND) && !hit;
    pattern_next = (state_next == S_SNAP) || (state_next == S_SEND) ||
                   (state_next == S_WAIT);
    busy_next    = (state_next == S_SETUP) || (state_next == S_SNAP) ||
                   (state_next == S_SEND)  || (state_next == S_WAIT) ||
                   (state_next == S_JUDGE);
    done_next    = (state_next == S_DONE);
  end

  assign link.tbit_period = tbit_reg;
  assign link.tx_pattern  = pattern_reg;
  assign link.tx_req      = req_reg;
  assign link.tx_data     = data_reg;
  assign busy             = busy_reg;
  assign done             = done_reg;
  assign step_idx         = step_reg;
  assign pass_map         = map_reg;

endmodule

// File: tb/tb_commu_sched.sv
// ---------------------------------------------------------------------------
// tb_commu_sched
//   Directed bench for commu_sched with a small N_STEP=2 table. A behavioural
//   model of the sweep predicts every output each cycle; literal checks pin
//   the headline numbers (latencies, pass maps, timeout distance).
// ---------------------------------------------------------------------------
module tb_commu_sched;
  localparam int N_STEP = 2;
  localparam int BPS    = 4;
  localparam int SETTLE = 3;
  localparam int TMO    = 100;
  localparam logic [19:0] TAB0 = 20'h00364;
  localparam logic [19:0] TAB1 = 20'h001B2;

  localparam int P_IDLE = 0, P_SETTLE = 1, P_SNAP = 2, P_SEND = 3,
                 P_WAIT = 4, P_JUDGE = 5, P_DONE = 6;

  logic        clk_sys = 1'b0;
  logic        rst     = 1'b1;
  logic        start   = 1'b0;
  logic        abort   = 1'b0;
  logic [39:0] period_tab = {TAB1, TAB0};
  logic        busy, done;
  logic [3:0]  step_idx;
  logic [1:0]  pass_map;
  logic        tx_ack = 1'b1;
  logic        block1 = 1'b0;
  logic [31:0] rx_off = 32'd0;
  logic [31:0] rx_cnt = 32'd0;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  commu_sched_if link();
  assign link.tx_ack   = tx_ack;
  assign link.rx_total = rx_off + rx_cnt;

  commu_sched #(
    .N_STEP(N_STEP), .BYTES_PER_STEP(BPS), .SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk_sys(clk_sys), .rst(rst), .start(start), .abort(abort),
    .period_tab(period_tab), .link(link),
    .busy(busy), .done(done), .step_idx(step_idx), .pass_map(pass_map)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=0x%0h exp=0x%0h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_phase = P_IDLE;
  logic [3:0]  m_step  = 4'd0;
  int          m_cnt   = 0;
  int          m_settle = 0;
  int          m_wait  = 0;
  logic [31:0] m_base  = 32'd0;
  logic [31:0] m_delta;
  logic        m_pass  = 1'b0;
  logic        m_req   = 1'b0;
  logic [1:0]  m_map   = 2'b00;
  logic [19:0] m_period = TAB0;
  bit          chk_en  = 1'b0;

  always @(posedge clk_sys) begin
    if (rst) begin
      m_phase = P_IDLE; m_period = TAB0; m_map = 2'b00; m_step = 4'd0;
      m_req = 1'b0; m_cnt = 0;
    end else if (abort && m_phase != P_IDLE) begin
      m_phase = P_IDLE; m_req = 1'b0;
    end else begin
      case (m_phase)
        P_IDLE: if (start) begin
          m_phase = P_SETTLE; m_step = 4'd0; m_map = 2'b00;
          m_settle = SETTLE; m_period = TAB0;
        end
        P_SETTLE: begin
          m_settle--;
          if (m_settle == 0) m_phase = P_SNAP;
        end
        P_SNAP: begin
          m_base = link.rx_total; m_cnt = 0; m_req = 1'b1; m_phase = P_SEND;
        end
        P_SEND: begin
          if (m_req && tx_ack) begin
            m_cnt++; m_req = 1'b0;
            if (m_cnt == BPS) begin m_phase = P_WAIT; m_wait = 0; end
          end else begin
            m_req = 1'b1;
          end
        end
        P_WAIT: begin
          m_wait++;
          m_delta = link.rx_total - m_base;
          if (m_delta >= 32'(BPS)) begin m_pass = 1'b1; m_phase = P_JUDGE; end
          else if (m_wait == TMO) begin m_pass = 1'b0; m_phase = P_JUDGE; end
        end
        P_JUDGE: begin
          m_map[m_step[0]] = m_pass;
          if (m_step == 4'(N_STEP - 1)) m_phase = P_DONE;
          else begin
            m_step = m_step + 4'd1; m_settle = SETTLE;
            m_period = (m_step == 4'd1) ? TAB1 : TAB0;
            m_phase = P_SETTLE;
          end
        end
        default: m_phase = P_IDLE;
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk_sys) begin
    if (chk_en) begin
      chk("tbit_period", 32'(link.tbit_period), 32'(m_period));
      chk("busy", 32'(busy), 32'(m_phase >= P_SETTLE && m_phase <= P_JUDGE));
      chk("done", 32'(done), 32'(m_phase == P_DONE));
      chk("tx_pattern", 32'(link.tx_pattern), 32'(m_phase >= P_SNAP && m_phase <= P_WAIT));
      chk("tx_req", 32'(link.tx_req), 32'(m_phase == P_SEND && m_req));
      chk("pass_map", 32'(pass_map), 32'(m_map));
      if (m_phase == P_SEND && m_req)
        chk("tx_data", 32'(link.tx_data), 32'({m_step, 4'(m_cnt)}));
      if (m_phase >= P_SETTLE && m_phase <= P_JUDGE)
        chk("step_idx", 32'(step_idx), 32'(m_step));
    end
  end

  // ---------------- monitor (one line per byte) ----------------
  int ack_cnt = 0, done_cnt = 0, last_ack_edge = 0, fall_edge = 0;
  logic prev_pat = 1'b0;
  always @(negedge clk_sys) begin
    if (link.tx_req && tx_ack) begin
      ack_cnt++;
      last_ack_edge = cyc + 1;
      $display("byte step=%0d data=0x%02h period=0x%05h", step_idx, link.tx_data, link.tbit_period);
    end
    if (done) done_cnt++;
    if (prev_pat && !link.tx_pattern) fall_edge = cyc;
    prev_pat = link.tx_pattern;
  end

  // ---------------- RX responder ----------------
  always begin
    logic h;
    @(negedge clk_sys);
    h = link.tx_req && tx_ack && !(block1 && link.tx_data[7:4] == 4'd1);
    @(posedge clk_sys);
    #1;
    if (h) rx_cnt = rx_cnt + 32'd1;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic run_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit saw1);
    bit ok = 1'b0;
    saw1 = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (link.tbit_period == TAB1) saw1 = 1'b1;
      if (done) begin ok = 1'b1; break; end
    end
    chk("done_within_budget", 32'(ok), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_tbit"}, 32'(link.tbit_period), 32'(TAB0));
    chk({tag, "_pattern"}, 32'(link.tx_pattern), 32'd0);
    chk({tag, "_req"}, 32'(link.tx_req), 32'd0);
    chk({tag, "_data"}, 32'(link.tx_data), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_step"}, 32'(step_idx), 32'd0);
    chk({tag, "_map"}, 32'(pass_map), 32'd0);
  endtask

  initial begin
    int n, a0, d0;
    bit saw1;
    logic [7:0] cap;

    tick();
    chk_en = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check_reset_vals("reset");

    // Loopback pass.
    a0 = ack_cnt; d0 = done_cnt;
    run_start();
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_tbit", 32'(link.tbit_period), 32'(TAB0));
    n = 0;
    while (!link.tx_req && n < 50) begin tick(); n++; end
    chk("first_req_latency", 32'(n), 32'(SETTLE + 1));
    wait_done(2000, saw1);
    chk("saw_tab1", 32'(saw1), 32'd1);
    tick();
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("loop_acks", 32'(ack_cnt - a0), 32'd8);
    chk("loop_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("loop_map", 32'(pass_map), 32'b11);

    // Timeout on step 1.
    block1 = 1'b1;
    run_start();
    wait_done(2000, saw1);
    tick();
    chk("tmo_map", 32'(pass_map), 32'b01);
    chk("tmo_distance", 32'(fall_edge - last_ack_edge), 32'(TMO));
    block1 = 1'b0;

    // rx_total wrap.
    rx_off = 32'hFFFF_FFFE - rx_cnt;
    run_start();
    wait_done(2000, saw1);
    tick();
    chk("wrap_map", 32'(pass_map), 32'b11);
    chk("wrap_rx_end", link.rx_total, 32'h0000_0006);

    // Abort in SEND of step 1.
    run_start();
    n = 0;
    while (!(link.tx_req && step_idx == 4'd1) && n < 200) begin tick(); n++; end
    chk("abort_reached_step1", 32'(n < 200), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_req", 32'(link.tx_req), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_pattern", 32'(link.tx_pattern), 32'd0);
    chk("abort_map", 32'(pass_map), 32'b01);
    d0 = done_cnt;
    repeat (20) tick();
    chk("abort_no_done", 32'(done_cnt), 32'(d0));
    run_start();
    wait_done(2000, saw1);
    tick();
    chk("after_abort_map", 32'(pass_map), 32'b11);

    // Handshake stall and ignored start.
    tx_ack = 1'b0;
    run_start();
    n = 0;
    while (!link.tx_req && n < 50) begin tick(); n++; end
    cap = link.tx_data;
    a0 = ack_cnt;
    for (int i = 0; i < 10; i++) begin
      start = (i == 3);
      tick();
      chk("stall_req", 32'(link.tx_req), 32'd1);
      chk("stall_data", 32'(link.tx_data), 32'(cap));
    end
    start = 1'b0;
    chk("stall_no_count", 32'(ack_cnt), 32'(a0));
    tx_ack = 1'b1;
    d0 = done_cnt;
    wait_done(2000, saw1);
    tick();
    chk("stall_map", 32'(pass_map), 32'b11);
    chk("stall_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Reset in WAIT of step 1.
    block1 = 1'b1;
    a0 = ack_cnt;
    run_start();
    n = 0;
    while (ack_cnt < a0 + 8 && n < 200) begin tick(); n++; end
    repeat (5) tick();
    chk("in_wait", 32'({link.tx_pattern, link.tx_req}), 32'b10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_vals("wait_reset");
    block1 = 1'b0;
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL global_timeout act=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/commu_sched.md
# commu_sched

Baud-sweep link test scheduler for the commu path. It steps the shared `tbit_period` through a table of bit periods. At each step it sends a fixed burst of pattern bytes through the TX side, then watches the RX byte counter (`rx_total`) to decide whether that step passes. It sits above the RX and TX tops, owns `tbit_period` and `tx_pattern` for both, and reports a per-step pass map to the host logic.

## Interface
Parameters:
- N_STEP, 4, number of table entries (1..16)
- BYTES_PER_STEP, 16, bytes sent per step (1..255)
- SETTLE_CYC, 64, idle cycles after each period change before the first byte (>=1)
- TIMEOUT_CYC, 2000000, max cycles to wait for RX after the last byte (fits 24 bits)

Ports:
- clk_sys  in  1  system clock
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle request to run a sweep
- abort  in  1  one-cycle request to stop a sweep
- period_tab  in  20*N_STEP  packed period table, step k at [20k+19:20k]
- tbit_period  out  20  bit period driven to RX/TX
- tx_pattern  out  1  pattern mode enable to RX/TX
- tx_req  out  1  byte send request
- tx_data  out  8  byte to send
- tx_ack  in  1  TX accepted the byte this cycle
- rx_total  in  32  cumulative good-byte count from RX
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse when a sweep completes
- step_idx  out  4  current step
- pass_map  out  N_STEP  bit k set when step k passed

## Operation
- FSM states: IDLE, SETUP, SNAP, SEND, WAIT, JUDGE, DONE.
- IDLE:
  - `start` -> SETUP with step=0, pass_map cleared, busy=1.
  - `start` while not IDLE is ignored.
- SETUP:
  - On entry, register `tbit_period` = period_tab[step] and clear the settle counter.
  - Stay SETTLE_CYC cycles, then go to SNAP.
- SNAP: latch `base` = rx_total for one cycle, clear byte_cnt, go to SEND.
- SEND:
  - `tx_req` = 1 and `tx_data` = {step[3:0], byte_cnt[3:0]}.
  - A cycle with tx_req & tx_ack counts one byte: byte_cnt+1, and tx_req drops for the next cycle (one-cycle gap between bytes).
  - After byte BYTES_PER_STEP is acked, go to WAIT with the timeout counter cleared.
  - tx_ack while tx_req=0 is ignored.
- WAIT:
  - delta = rx_total - base, a 32-bit modulo subtraction, so rx_total wrap is harmless.
  - delta >= BYTES_PER_STEP -> JUDGE with pass=1.
  - Timeout counter reaches TIMEOUT_CYC -> JUDGE with pass=0.
  - If both occur in the same cycle, pass wins.
- JUDGE:
  - Write pass_map[step] = pass.
  - If step == N_STEP-1, go to DONE; else step+1 and go to SETUP.
- DONE: done=1 for one cycle, busy=0, return to IDLE. pass_map holds until the next start.
- `tx_pattern` = 1 in SNAP, SEND and WAIT; 0 elsewhere.
- `abort` in any non-IDLE state:
  - Go to IDLE next cycle with tx_req=0, tx_pattern=0, busy=0 and no done pulse.
  - pass_map keeps the steps already judged.
  - abort has priority over every other transition.
- `tbit_period` holds its last value in IDLE and DONE. It changes only on SETUP entry.

## Timing
- Reset values: tbit_period=period_tab[0] sampled at reset, tx_pattern=0, tx_req=0, tx_data=0, busy=0, done=0, step_idx=0, pass_map=0, FSM=IDLE.
- Reset mid-sweep behaves like abort, but also clears pass_map.
- All outputs are registered.
- `start` sampled high at edge T gives busy=1 and new tbit_period at T+1.
- First tx_req at T+1+SETTLE_CYC+1 (the extra cycle is SNAP).
- Fastest per-byte throughput: 2 cycles (ack in the first cycle of a request).
- JUDGE lasts 1 cycle. pass_map[k] updates at the edge leaving JUDGE.
- done pulses exactly one cycle, one cycle after the final JUDGE.
- step_idx is valid from SETUP entry through JUDGE.

## Test plan
- **Loopback pass:** N_STEP=2, BYTES_PER_STEP=4, SETTLE_CYC=3, tx_ack tied 1, rx_total incremented one cycle after each ack -> tbit_period goes tab[0] then tab[1], 8 tx_req/ack pairs, done pulse, pass_map=2'b11.
- **Timeout fail:** step 1 never increments rx_total, TIMEOUT_CYC=100 -> step 1 leaves WAIT exactly 100 cycles after its last ack, pass_map=2'b01, done pulses.
- **Counter wrap:** base rx_total=32'hFFFF_FFFE and 4 increments (ends at 32'h2) -> step passes.
- **Abort:** abort asserted in SEND of step 1 -> tx_req=0 and busy=0 next cycle, no done pulse, pass_map=2'b01. A later start runs a full sweep.
- **Handshake stall:** tx_ack held low 10 cycles -> tx_req stays high and tx_data stable; byte_cnt advances only on ack.
- **Ignored events:** start while busy, and tx_ack while tx_req=0 -> no effect on state or counts. Reset in WAIT -> all outputs at reset values next cycle.
